// File: rtl/mul_seq_arb.sv
// Round-robin arbiter and sequencer for a shared fixed-latency sequential multiplier.
// Define MUL_SEQ_ARB_B2B_EN to re-arbitrate on the result handshake so back-to-back ops have no bubble.
module mul_seq_arb #(
    parameter int NUM_CYC = 3,
    parameter int TAG_W   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [TAG_W-1:0] req1_tag,
    input  logic             flush,
    output logic             mul_start,
    output logic             mul_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_src,
    output logic             busy
);

    localparam int CNT_W = (NUM_CYC > 1) ? $clog2(NUM_CYC) : 1;

    if (NUM_CYC < 1) begin : g_bad_num_cyc
        $error("mul_seq_arb: NUM_CYC must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rr_ptr_q, rr_ptr_d;

    logic               arb_ptr;
    logic               arb_any;
    logic               arb_win;
    logic               do_grant;
    logic               kill;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            tag_q    <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // In DONE the pointer a handshake is about to write (~owner) already sets priority.
    always_comb begin
        arb_ptr = (state_q == DONE) ? ~owner_q : rr_ptr_q;
        arb_any = req0_valid | req1_valid;
        arb_win = (arb_ptr ? req1_valid : req0_valid) ? arb_ptr : ~arb_ptr;
    end

    assign kill = flush | ~rst_n;
    assign busy = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        tag_d      = tag_q;
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mul_start  = 1'b0;
        mul_sel    = owner_q;
        out_valid  = 1'b0;
        out_tag    = '0;
        out_src    = 1'b0;
        do_grant   = 1'b0;

        case (state_q)
            IDLE: begin
                do_grant = arb_any;
            end
            BUSY: begin
                if (cnt_q == CNT_W'(NUM_CYC - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_tag   = tag_q;
                out_src   = owner_q;
                if (out_ready) begin
                    rr_ptr_d = ~owner_q;
                    state_d  = IDLE;
`ifdef MUL_SEQ_ARB_B2B_EN
                    do_grant = arb_any;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_grant) begin
            req0_ready = ~arb_win;
            req1_ready = arb_win;
            mul_start  = 1'b1;
            mul_sel    = arb_win;
            owner_d    = arb_win;
            tag_d      = arb_win ? req1_tag : req0_tag;
            cnt_d      = '0;
            state_d    = BUSY;
        end

        // Flush or reset wins over everything: no handshake of any kind this cycle.
        if (kill) begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
            mul_start  = 1'b0;
            mul_sel    = owner_q;
            out_valid  = 1'b0;
            owner_d    = owner_q;
            tag_d      = tag_q;
            rr_ptr_d   = rr_ptr_q;
            cnt_d      = '0;
            state_d    = IDLE;
        end
    end

endmodule

// File: tb/tb_mul_seq_arb.sv
// Directed self-checking bench for mul_seq_arb (NUM_CYC=3, TAG_W=6); follows MUL_SEQ_ARB_B2B_EN if defined.
module tb_mul_seq_arb;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [5:0] req0_tag, req1_tag;
    logic       flush;
    logic       mul_start, mul_sel;
    logic       out_valid, out_ready;
    logic [5:0] out_tag;
    logic       out_src;
    logic       busy;

    int passCount  = 0;
    int checkCount = 0;

`ifdef MUL_SEQ_ARB_B2B_EN
    localparam int PERIOD = 4;
`else
    localparam int PERIOD = 5;
`endif

    mul_seq_arb #(.NUM_CYC(3), .TAG_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_tag(req1_tag),
        .flush(flush), .mul_start(mul_start), .mul_sel(mul_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_src(out_src), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Control snapshot {req0_ready, req1_ready, mul_start, mul_sel, out_valid, busy}.
    function automatic logic [5:0] ctl();
        return {req0_ready, req1_ready, mul_start, mul_sel, out_valid, busy};
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [5:0] t0, input logic v1,
                                 input logic [5:0] t1, input logic ordy, input logic fl);
        req0_valid = v0; req0_tag = t0;
        req1_valid = v1; req1_tag = t1;
        out_ready  = ordy; flush = fl;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
        repeat (2) nextCycle();
        rst_n = 1'b1;
        nextCycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(1'b1, 6'h05, 1'b0, 6'h00, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            nextCycle();
            #1;
            if (ctl() !== 6'b000000) $display("[TB] FAIL reset_ctl%0d got %b exp %b", c, ctl(), 6'b000000);
            else passCount++;
            checkCount++;
        end
        nextCycle();
        rst_n = 1'b1;
        #1;
        if (ctl() !== 6'b101000) $display("[TB] FAIL reset_release_grant got %b exp %b", ctl(), 6'b101000);
        else passCount++;
        checkCount++;
    endtask

    task automatic test_single_op();
        logic [5:0] expCtl;
        doReset();
        applyStimulus(1'b1, 6'h2A, 1'b0, 6'h00, 1'b1, 1'b0);
        #1;
        if (ctl() !== 6'b101000) $display("[TB] FAIL single_c0 got %b exp %b", ctl(), 6'b101000);
        else passCount++;
        checkCount++;
        for (int c = 1; c <= 5; c++) begin
            nextCycle();
            applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b1, 1'b0);
            #1;
            expCtl = (c <= 3) ? 6'b000001 : (c == 4) ? 6'b000011 : 6'b000000;
            if (ctl() !== expCtl) $display("[TB] FAIL single_c%0d got %b exp %b", c, ctl(), expCtl);
            else passCount++;
            checkCount++;
            if (c == 4) begin
                if ({out_tag, out_src} !== {6'h2A, 1'b0})
                    $display("[TB] FAIL single_result tag/src got %h/%b exp 2a/0", out_tag, out_src);
                else passCount++;
                checkCount++;
            end
        end
    endtask

    task automatic test_round_robin();
        int         n;
        int         hsCycle[4];
        logic       hsSrc[4];
        logic [5:0] hsTag[4];
        doReset();
        n = 0;
        applyStimulus(1'b1, 6'h01, 1'b1, 6'h11, 1'b1, 1'b0);
        for (int c = 0; c < 26; c++) begin
            if (c > 0) nextCycle();
            #1;
            if (out_valid && out_ready && n < 4) begin
                hsCycle[n] = c; hsSrc[n] = out_src; hsTag[n] = out_tag;
                n++;
            end
        end
        if (n !== 4) $display("[TB] FAIL rr_count got %0d exp 4", n);
        else passCount++;
        checkCount++;
        for (int i = 0; i < n; i++) begin
            if (hsSrc[i] !== 1'(i % 2)) $display("[TB] FAIL rr_src%0d got %b exp %b", i, hsSrc[i], 1'(i % 2));
            else passCount++;
            checkCount++;
            if (hsTag[i] !== ((i % 2) ? 6'h11 : 6'h01))
                $display("[TB] FAIL rr_tag%0d got %h exp %h", i, hsTag[i], (i % 2) ? 6'h11 : 6'h01);
            else passCount++;
            checkCount++;
            if (hsCycle[i] !== 4 + i * PERIOD)
                $display("[TB] FAIL rr_cycle%0d got %0d exp %0d", i, hsCycle[i], 4 + i * PERIOD);
            else passCount++;
            checkCount++;
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] expCtl;
        doReset();
        applyStimulus(1'b0, 6'h00, 1'b1, 6'h3C, 1'b0, 1'b0);
        #1;
        if (ctl() !== 6'b011100) $display("[TB] FAIL bp_c0 got %b exp %b", ctl(), 6'b011100);
        else passCount++;
        checkCount++;
        for (int c = 1; c <= 11; c++) begin
            nextCycle();
            applyStimulus(1'b1, 6'h07, 1'b1, 6'h08, (c >= 10), 1'b0);
            #1;
            if (c <= 3) expCtl = 6'b000101;
            else if (c <= 9) expCtl = 6'b000111;
`ifdef MUL_SEQ_ARB_B2B_EN
            else if (c == 10) expCtl = 6'b101011;
            else expCtl = 6'b000001;
`else
            else if (c == 10) expCtl = 6'b000111;
            else expCtl = 6'b101000;
`endif
            if (ctl() !== expCtl) $display("[TB] FAIL bp_c%0d got %b exp %b", c, ctl(), expCtl);
            else passCount++;
            checkCount++;
            if (c >= 4 && c <= 10) begin
                if ({out_tag, out_src} !== {6'h3C, 1'b1})
                    $display("[TB] FAIL bp_hold_c%0d tag/src got %h/%b exp 3c/1", c, out_tag, out_src);
                else passCount++;
                checkCount++;
            end
        end
    endtask

    task automatic test_flush();
        logic sawValid;
        doReset();
        applyStimulus(1'b1, 6'h15, 1'b0, 6'h00, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b1, 1'b0);
        nextCycle();
        flush = 1'b1;
        #1;
        if (ctl() !== 6'b000001) $display("[TB] FAIL flush_busy_c2 got %b exp %b", ctl(), 6'b000001);
        else passCount++;
        checkCount++;
        nextCycle();
        flush = 1'b0;
        #1;
        if (ctl() !== 6'b000000) $display("[TB] FAIL flush_idle_c3 got %b exp %b", ctl(), 6'b000000);
        else passCount++;
        checkCount++;
        sawValid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            nextCycle();
            #1;
            sawValid = sawValid | out_valid;
        end
        if (sawValid !== 1'b0) $display("[TB] FAIL flush_no_result got %b exp 0", sawValid);
        else passCount++;
        checkCount++;
        // Second op flushed while in DONE with out_ready high.
        applyStimulus(1'b1, 6'h16, 1'b0, 6'h00, 1'b1, 1'b0);
        repeat (4) begin
            nextCycle();
            applyStimulus(1'b0, 6'h00, 1'b0, 6'h00, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 6'h17, 1'b1, 6'h18, 1'b1, 1'b1);
        #1;
        if (ctl() !== 6'b000001) $display("[TB] FAIL flush_done got %b exp %b", ctl(), 6'b000001);
        else passCount++;
        checkCount++;
        nextCycle();
        flush = 1'b0;
        #1;
        if (ctl() !== 6'b101000) $display("[TB] FAIL flush_rr_kept got %b exp %b", ctl(), 6'b101000);
        else passCount++;
        checkCount++;
    endtask

    task automatic test_idle_starvation();
        doReset();
        applyStimulus(1'b0, 6'h00, 1'b1, 6'h22, 1'b1, 1'b0);
        #1;
        if (ctl() !== 6'b011100) $display("[TB] FAIL starve_grant got %b exp %b", ctl(), 6'b011100);
        else passCount++;
        checkCount++;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_idle_starvation();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
